// File: rtl/inst_encoder_pkg.sv
// Shared instruction-set constants for the RV32I encoder and decoder:
// instruction type codes (TYPE_BIT wide), opcodes, funct3 values, and a
// lookup that maps a type code to its format, opcode, funct3 and the
// funct7 "alternate" bit (SUB/SRA/SRAI).
package inst_encoder_pkg;

  localparam int unsigned TYPE_BIT  = 7;
  localparam int unsigned NUM_TYPES = 37;

  typedef enum logic [TYPE_BIT-1:0] {
    T_LUI, T_AUIPC, T_JAL, T_JALR,
    T_LB, T_LH, T_LW, T_LBU, T_LHU,
    T_SB, T_SH, T_SW,
    T_BEQ, T_BNE, T_BLT, T_BGE, T_BLTU, T_BGEU,
    T_ADDI, T_SLTI, T_SLTIU, T_XORI, T_ORI, T_ANDI,
    T_SLLI, T_SRLI, T_SRAI,
    T_ADD, T_SUB, T_SLL, T_SLT, T_SLTU, T_XOR, T_SRL, T_SRA, T_OR, T_AND
  } inst_type_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_U, FMT_J, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_R, FMT_BAD
  } fmt_e;

  typedef struct packed {
    fmt_e       fmt;
    logic [6:0] op;
    logic [2:0] f3;
    logic       alt;  // funct7 = 0100000 when set
  } type_info_t;

  function automatic type_info_t type_info(input logic [TYPE_BIT-1:0] t);
    type_info_t r;
    r = '{FMT_BAD, 7'b0, 3'b0, 1'b0};
    case (t)
      T_LUI:   r = '{FMT_U,  OP_LUI,    3'b000, 1'b0};
      T_AUIPC: r = '{FMT_U,  OP_AUIPC,  3'b000, 1'b0};
      T_JAL:   r = '{FMT_J,  OP_JAL,    3'b000, 1'b0};
      T_JALR:  r = '{FMT_I,  OP_JALR,   3'b000, 1'b0};
      T_LB:    r = '{FMT_I,  OP_LOAD,   3'b000, 1'b0};
      T_LH:    r = '{FMT_I,  OP_LOAD,   3'b001, 1'b0};
      T_LW:    r = '{FMT_I,  OP_LOAD,   3'b010, 1'b0};
      T_LBU:   r = '{FMT_I,  OP_LOAD,   3'b100, 1'b0};
      T_LHU:   r = '{FMT_I,  OP_LOAD,   3'b101, 1'b0};
      T_SB:    r = '{FMT_S,  OP_STORE,  3'b000, 1'b0};
      T_SH:    r = '{FMT_S,  OP_STORE,  3'b001, 1'b0};
      T_SW:    r = '{FMT_S,  OP_STORE,  3'b010, 1'b0};
      T_BEQ:   r = '{FMT_B,  OP_BRANCH, 3'b000, 1'b0};
      T_BNE:   r = '{FMT_B,  OP_BRANCH, 3'b001, 1'b0};
      T_BLT:   r = '{FMT_B,  OP_BRANCH, 3'b100, 1'b0};
      T_BGE:   r = '{FMT_B,  OP_BRANCH, 3'b101, 1'b0};
      T_BLTU:  r = '{FMT_B,  OP_BRANCH, 3'b110, 1'b0};
      T_BGEU:  r = '{FMT_B,  OP_BRANCH, 3'b111, 1'b0};
      T_ADDI:  r = '{FMT_I,  OP_IMM,    3'b000, 1'b0};
      T_SLTI:  r = '{FMT_I,  OP_IMM,    3'b010, 1'b0};
      T_SLTIU: r = '{FMT_I,  OP_IMM,    3'b011, 1'b0};
      T_XORI:  r = '{FMT_I,  OP_IMM,    3'b100, 1'b0};
      T_ORI:   r = '{FMT_I,  OP_IMM,    3'b110, 1'b0};
      T_ANDI:  r = '{FMT_I,  OP_IMM,    3'b111, 1'b0};
      T_SLLI:  r = '{FMT_SH, OP_IMM,    3'b001, 1'b0};
      T_SRLI:  r = '{FMT_SH, OP_IMM,    3'b101, 1'b0};
      T_SRAI:  r = '{FMT_SH, OP_IMM,    3'b101, 1'b1};
      T_ADD:   r = '{FMT_R,  OP_REG,    3'b000, 1'b0};
      T_SUB:   r = '{FMT_R,  OP_REG,    3'b000, 1'b1};
      T_SLL:   r = '{FMT_R,  OP_REG,    3'b001, 1'b0};
      T_SLT:   r = '{FMT_R,  OP_REG,    3'b010, 1'b0};
      T_SLTU:  r = '{FMT_R,  OP_REG,    3'b011, 1'b0};
      T_XOR:   r = '{FMT_R,  OP_REG,    3'b100, 1'b0};
      T_SRL:   r = '{FMT_R,  OP_REG,    3'b101, 1'b0};
      T_SRA:   r = '{FMT_R,  OP_REG,    3'b101, 1'b1};
      T_OR:    r = '{FMT_R,  OP_REG,    3'b110, 1'b0};
      T_AND:   r = '{FMT_R,  OP_REG,    3'b111, 1'b0};
      default: r = '{FMT_BAD, 7'b0, 3'b0, 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inst_encoder_fifo.sv
// inst_fifo: parametric synchronous FIFO, 2**DEPTH_LOG entries of WIDTH bits.
// Ports: clk_in, rst_in (async active-low), push_in/din, pop_in/dout,
// full_out, empty_out, count_out. While empty, dout holds the last popped
// word (0 after reset).
module inst_fifo #(
  parameter int unsigned DEPTH_LOG = 2,
  parameter int unsigned WIDTH     = 64
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 push_in,
  input  logic [WIDTH-1:0]     din,
  input  logic                 pop_in,
  output logic [WIDTH-1:0]     dout,
  output logic                 full_out,
  output logic                 empty_out,
  output logic [DEPTH_LOG:0]   count_out
);

  localparam int unsigned        DEPTH    = 2 ** DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic [WIDTH-1:0]     hold_q, hold_d;
  logic                 do_push, do_pop;

  assign full_out  = (count_q == FULL_CNT);
  assign empty_out = (count_q == '0);
  assign count_out = count_q;
  assign do_push   = push_in & ~full_out;
  assign do_pop    = pop_in & ~empty_out;
  assign dout      = empty_out ? hold_q : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      hold_d   = mem_q[rd_ptr_q];
    end
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: encodes decoded RV32I fields (type, rs1, rs2, rd, imm) into
// 32-bit machine words and queues them, each tagged with a sequential byte
// address, in an inst_fifo.
// Inputs: clk_in, rst_in (async active-low), rdy_in (global pause), in_valid,
// type_in/rs1_in/rs2_in/rd_in/imm_in, addr_clr_in, err_clr_in, out_ready.
// Outputs: in_ready, out_valid, out_inst, out_addr, err_out (sticky),
// count_out.
// Build option: define IMM_CHECK_EN to flag out-of-range immediates in err_out.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [TYPE_BIT-1:0] type_in,
  input  logic [4:0]          rs1_in,
  input  logic [4:0]          rs2_in,
  input  logic [4:0]          rd_in,
  input  logic [31:0]         imm_in,
  input  logic                addr_clr_in,
  input  logic                err_clr_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_inst,
  output logic [31:0]         out_addr,
  output logic                err_out,
  output logic [DEPTH_LOG:0]  count_out
);

  type_info_t  info;
  logic [6:0]  f7;
  logic [31:0] enc_word;
  logic        enc_bad, imm_bad;
  logic        full, empty, push, pop;
  logic [31:0] entry_addr, addr_q, addr_d;
  logic        err_q, err_d;

  assign info = type_info(type_in);
  assign f7   = {1'b0, info.alt, 5'b0};

  always_comb begin
    enc_word = 32'h0000_0013;
    enc_bad  = 1'b0;
    case (info.fmt)
      FMT_U:   enc_word = {imm_in[31:12], rd_in, info.op};
      FMT_J:   enc_word = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12], rd_in, info.op};
      FMT_I:   enc_word = {imm_in[11:0], rs1_in, info.f3, rd_in, info.op};
      FMT_SH:  enc_word = {f7, imm_in[4:0], rs1_in, info.f3, rd_in, info.op};
      FMT_S:   enc_word = {imm_in[11:5], rs2_in, rs1_in, info.f3, imm_in[4:0], info.op};
      FMT_B:   enc_word = {imm_in[12], imm_in[10:5], rs2_in, rs1_in, info.f3, imm_in[4:1], imm_in[11], info.op};
      FMT_R:   enc_word = {f7, rs2_in, rs1_in, info.f3, rd_in, info.op};
      default: enc_bad  = 1'b1;
    endcase
  end

`ifdef IMM_CHECK_EN
  always_comb begin
    imm_bad = 1'b0;
    case (info.fmt)
      FMT_I, FMT_S: imm_bad = (imm_in[31:11] != {21{imm_in[11]}});
      FMT_B:        imm_bad = (imm_in[31:12] != {20{imm_in[12]}}) | imm_in[0];
      FMT_J:        imm_bad = (imm_in[31:20] != {12{imm_in[20]}}) | imm_in[0];
      FMT_U:        imm_bad = (imm_in[11:0] != '0);
      FMT_SH:       imm_bad = (imm_in[31:5] != '0);
      default:      imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  // rst_in gates in_ready so nothing is accepted while reset is held.
  assign in_ready  = rdy_in & ~full & rst_in;
  assign push      = in_valid & in_ready;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready & rdy_in;
  assign err_out   = err_q;

  // A clear coinciding with a push restarts addressing at that very entry.
  assign entry_addr = addr_clr_in ? BASE_ADDR : addr_q;

  always_comb begin
    addr_d = addr_q;
    err_d  = err_q;
    if (rdy_in) begin
      if (push) addr_d = entry_addr + 32'd4;
      else if (addr_clr_in) addr_d = BASE_ADDR;
      if (push && (enc_bad || imm_bad)) err_d = 1'b1;
      else if (err_clr_in) err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  inst_fifo #(
    .DEPTH_LOG (DEPTH_LOG),
    .WIDTH     (64)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (push),
    .din       ({entry_addr, enc_word}),
    .pop_in    (pop),
    .dout      ({out_addr, out_inst}),
    .full_out  (full),
    .empty_out (empty),
    .count_out (count_out)
  );

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int unsigned DL   = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int FU = 0, FJ = 1, FI = 2, FSH = 3, FS = 4, FB = 5, FR = 6;

  logic clk = 1'b0, rst_in = 1'b0, rdy_in = 1'b1;
  logic in_valid = 1'b0, in_ready, addr_clr_in = 1'b0, err_clr_in = 1'b0;
  logic out_valid, out_ready = 1'b0, err_out;
  logic [6:0]  type_in = '0;
  logic [4:0]  rs1_in = '0, rs2_in = '0, rd_in = '0;
  logic [31:0] imm_in = '0, out_inst, out_addr;
  logic [DL:0] count_out;

  int errors = 0, checks = 0;

  typedef struct {
    int          t;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, addr;
  } rec_t;

  rec_t        q[$];
  logic [31:0] addr_m;

  inst_encoder #(.DEPTH_LOG(DL), .BASE_ADDR(BASE)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .in_valid(in_valid),
    .in_ready(in_ready), .type_in(type_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
    .rd_in(rd_in), .imm_in(imm_in), .addr_clr_in(addr_clr_in),
    .err_clr_in(err_clr_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .err_out(err_out),
    .count_out(count_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // RV32I instruction table as the decoder sees it.
  function automatic void tinfo(input logic [6:0] t, output int fmt,
                                output logic [6:0] op, output logic [2:0] f3,
                                output logic alt);
    fmt = -1; op = '0; f3 = '0; alt = 1'b0;
    case (t)
      T_LUI:   begin fmt = FU;  op = 7'h37; end
      T_AUIPC: begin fmt = FU;  op = 7'h17; end
      T_JAL:   begin fmt = FJ;  op = 7'h6F; end
      T_JALR:  begin fmt = FI;  op = 7'h67; f3 = 3'd0; end
      T_LB:    begin fmt = FI;  op = 7'h03; f3 = 3'd0; end
      T_LH:    begin fmt = FI;  op = 7'h03; f3 = 3'd1; end
      T_LW:    begin fmt = FI;  op = 7'h03; f3 = 3'd2; end
      T_LBU:   begin fmt = FI;  op = 7'h03; f3 = 3'd4; end
      T_LHU:   begin fmt = FI;  op = 7'h03; f3 = 3'd5; end
      T_SB:    begin fmt = FS;  op = 7'h23; f3 = 3'd0; end
      T_SH:    begin fmt = FS;  op = 7'h23; f3 = 3'd1; end
      T_SW:    begin fmt = FS;  op = 7'h23; f3 = 3'd2; end
      T_BEQ:   begin fmt = FB;  op = 7'h63; f3 = 3'd0; end
      T_BNE:   begin fmt = FB;  op = 7'h63; f3 = 3'd1; end
      T_BLT:   begin fmt = FB;  op = 7'h63; f3 = 3'd4; end
      T_BGE:   begin fmt = FB;  op = 7'h63; f3 = 3'd5; end
      T_BLTU:  begin fmt = FB;  op = 7'h63; f3 = 3'd6; end
      T_BGEU:  begin fmt = FB;  op = 7'h63; f3 = 3'd7; end
      T_ADDI:  begin fmt = FI;  op = 7'h13; f3 = 3'd0; end
      T_SLTI:  begin fmt = FI;  op = 7'h13; f3 = 3'd2; end
      T_SLTIU: begin fmt = FI;  op = 7'h13; f3 = 3'd3; end
      T_XORI:  begin fmt = FI;  op = 7'h13; f3 = 3'd4; end
      T_ORI:   begin fmt = FI;  op = 7'h13; f3 = 3'd6; end
      T_ANDI:  begin fmt = FI;  op = 7'h13; f3 = 3'd7; end
      T_SLLI:  begin fmt = FSH; op = 7'h13; f3 = 3'd1; end
      T_SRLI:  begin fmt = FSH; op = 7'h13; f3 = 3'd5; end
      T_SRAI:  begin fmt = FSH; op = 7'h13; f3 = 3'd5; alt = 1'b1; end
      T_ADD:   begin fmt = FR;  op = 7'h33; f3 = 3'd0; end
      T_SUB:   begin fmt = FR;  op = 7'h33; f3 = 3'd0; alt = 1'b1; end
      T_SLL:   begin fmt = FR;  op = 7'h33; f3 = 3'd1; end
      T_SLT:   begin fmt = FR;  op = 7'h33; f3 = 3'd2; end
      T_SLTU:  begin fmt = FR;  op = 7'h33; f3 = 3'd3; end
      T_XOR:   begin fmt = FR;  op = 7'h33; f3 = 3'd4; end
      T_SRL:   begin fmt = FR;  op = 7'h33; f3 = 3'd5; end
      T_SRA:   begin fmt = FR;  op = 7'h33; f3 = 3'd5; alt = 1'b1; end
      T_OR:    begin fmt = FR;  op = 7'h33; f3 = 3'd6; end
      T_AND:   begin fmt = FR;  op = 7'h33; f3 = 3'd7; end
      default: fmt = -1;
    endcase
  endfunction

  // Reference decoder: word -> type code, format and immediate.
  function automatic void decode(input logic [31:0] w, output int t,
                                 output int fmt, output logic [31:0] imm);
    int f; logic [6:0] op; logic [2:0] f3; logic alt;
    t = -1; fmt = -1; imm = '0;
    for (int k = NUM_TYPES - 1; k >= 0; k--) begin
      tinfo(7'(k), f, op, f3, alt);
      if (op == w[6:0] && (f <= FJ || f3 == w[14:12]) &&
          (!(f == FSH || f == FR) || w[31:25] == {1'b0, alt, 5'b0})) begin
        t = k; fmt = f;
      end
    end
    case (fmt)
      FU:  imm = {w[31:12], 12'b0};
      FJ:  imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      FI:  imm = {{20{w[31]}}, w[31:20]};
      FSH: imm = {27'b0, w[24:20]};
      FS:  imm = {{20{w[31]}}, w[31:25], w[11:7]};
      FB:  imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: imm = '0;
    endcase
  endfunction

  // Random legal instruction fields.
  function automatic rec_t gen();
    rec_t r; int f; logic [6:0] op; logic [2:0] f3; logic alt; logic [31:0] v;
    r.t = $urandom_range(0, NUM_TYPES - 1);
    r.rd = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
    v = $urandom; r.addr = '0;
    tinfo(7'(r.t), f, op, f3, alt);
    case (f)
      FU:  r.imm = v & 32'hFFFF_F000;
      FJ:  r.imm = {{11{v[20]}}, v[20:1], 1'b0};
      FI, FS: r.imm = {{20{v[11]}}, v[11:0]};
      FSH: r.imm = {27'b0, v[4:0]};
      FB:  r.imm = {{19{v[12]}}, v[12:1], 1'b0};
      default: r.imm = v;
    endcase
    return r;
  endfunction

  task automatic drive(input rec_t r);
    type_in = 7'(r.t); rd_in = r.rd; rs1_in = r.rs1; rs2_in = r.rs2; imm_in = r.imm;
  endtask

  task automatic test_reset();
    @(negedge clk);
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || count_out !== '0) begin errors++; $display("FAIL reset_empty: valid=%b count=%0d want 0/0", out_valid, count_out); end
    checks++;
    if (out_inst !== 32'h0 || out_addr !== 32'h0 || err_out !== 1'b0) begin
      errors++; $display("FAIL reset_outs: inst=%h addr=%h err=%b want 0", out_inst, out_addr, err_out);
    end
    checks++;
    rst_in = 1'b1;
    @(negedge clk);
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
    checks++;
    addr_m = BASE;
  endtask

  task automatic test_vectors();
    in_valid = 1; type_in = T_LUI; rd_in = 5; rs1_in = 0; rs2_in = 0; imm_in = 32'h1234_5000;
    @(negedge clk); in_valid = 0;
    if (out_valid !== 1'b1 || out_inst !== 32'h1234_52B7 || out_addr !== addr_m) begin
      errors++; $display("FAIL lui: valid=%b inst=%h addr=%h want 1/123452b7/%h", out_valid, out_inst, out_addr, addr_m);
    end
    checks++;
    out_ready = 1; @(negedge clk); out_ready = 0;
    if (out_valid !== 1'b0 || out_inst !== 32'h1234_52B7) begin
      errors++; $display("FAIL empty_hold: valid=%b inst=%h want 0/123452b7", out_valid, out_inst);
    end
    checks++;
    in_valid = 1; addr_clr_in = 1; type_in = T_ADDI; rd_in = 1; rs1_in = 0; imm_in = 32'hFFFF_FFFF;
    @(negedge clk); addr_clr_in = 0;
    type_in = T_SUB; rd_in = 3; rs1_in = 1; rs2_in = 2;
    @(negedge clk); in_valid = 0;
    if (count_out !== 3'd2 || out_inst !== 32'hFFF0_0093 || out_addr !== BASE) begin
      errors++; $display("FAIL addi: count=%0d inst=%h addr=%h want 2/fff00093/%h", count_out, out_inst, out_addr, BASE);
    end
    checks++;
    out_ready = 1; @(negedge clk);
    if (out_inst !== 32'h4020_81B3 || out_addr !== BASE + 4) begin
      errors++; $display("FAIL sub: inst=%h addr=%h want 402081b3/%h", out_inst, out_addr, BASE + 4);
    end
    checks++;
    @(negedge clk); out_ready = 0;
    addr_m = BASE + 8;
    in_valid = 1; type_in = T_BEQ; rs1_in = 0; rs2_in = 0; imm_in = 32'hFFFF_FFFC;
    @(negedge clk);
    if (out_inst !== 32'hFE00_0EE3 || out_addr !== addr_m || count_out !== 3'd1) begin
      errors++; $display("FAIL beq: inst=%h addr=%h count=%0d want fe000ee3/%h/1", out_inst, out_addr, count_out, addr_m);
    end
    checks++;
    type_in = T_SRAI; rd_in = 7; rs1_in = 7; imm_in = 32'd3; out_ready = 1;
    @(negedge clk); in_valid = 0;
    if (out_inst !== 32'h4033_D393 || out_addr !== addr_m + 4 || count_out !== 3'd1) begin
      errors++; $display("FAIL srai_pushpop: inst=%h addr=%h count=%0d want 4033d393/%h/1", out_inst, out_addr, count_out, addr_m + 4);
    end
    checks++;
    @(negedge clk); out_ready = 0;
    addr_m = addr_m + 8;
  endtask

  task automatic test_full();
    rec_t r[5]; int t, f; logic [31:0] im;
    addr_clr_in = 1; @(negedge clk); addr_clr_in = 0; addr_m = BASE;
    for (int i = 0; i < 5; i++) begin
      r[i] = gen(); r[i].addr = addr_m + 32'(4 * i);
      if (in_ready !== (i < 4)) begin errors++; $display("FAIL full_ready[%0d]: got %b want %b", i, in_ready, i < 4); end
      checks++;
      drive(r[i]); in_valid = 1;
      @(negedge clk);
    end
    in_valid = 0;
    if (count_out !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_count: count=%0d ready=%b want 4/0", count_out, in_ready);
    end
    checks++;
    rdy_in = 0; out_ready = 1; in_valid = 1; addr_clr_in = 1; err_clr_in = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (count_out !== 3'd4 || out_valid !== 1'b1 || in_ready !== 1'b0 || out_addr !== r[0].addr) begin
        errors++; $display("FAIL pause: count=%0d valid=%b ready=%b addr=%h want 4/1/0/%h", count_out, out_valid, in_ready, out_addr, r[0].addr);
      end
      checks++;
    end
    rdy_in = 1; in_valid = 0; addr_clr_in = 0; err_clr_in = 0;
    for (int k = 0; k < 4; k++) begin
      decode(out_inst, t, f, im);
      if (out_valid !== 1'b1 || out_addr !== r[k].addr || t !== r[k].t) begin
        errors++; $display("FAIL drain[%0d]: valid=%b addr=%h type=%0d want 1/%h/%0d", k, out_valid, out_addr, t, r[k].addr, r[k].t);
      end
      checks++;
      @(negedge clk);
    end
    out_ready = 0;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drained: valid=%b want 0", out_valid); end
    checks++;
    drive(r[4]); in_valid = 1; @(negedge clk); in_valid = 0;
    if (out_addr !== r[4].addr) begin errors++; $display("FAIL fifth_addr: got %h want %h", out_addr, r[4].addr); end
    checks++;
    out_ready = 1; @(negedge clk); out_ready = 0;
    addr_m = r[4].addr + 4;
  endtask

  task automatic test_error();
    in_valid = 1; type_in = 7'h7F; @(negedge clk); in_valid = 0;
    if (out_inst !== 32'h0000_0013 || err_out !== 1'b1 || out_addr !== addr_m) begin
      errors++; $display("FAIL unknown: inst=%h err=%b addr=%h want 00000013/1/%h", out_inst, err_out, out_addr, addr_m);
    end
    checks++;
    out_ready = 1; repeat (2) @(negedge clk); out_ready = 0;
    if (err_out !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_out); end
    checks++;
    err_clr_in = 1; @(negedge clk); err_clr_in = 0;
    if (err_out !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", err_out); end
    checks++;
    in_valid = 1; err_clr_in = 1; type_in = 7'h7F; @(negedge clk); in_valid = 0; err_clr_in = 0;
    if (err_out !== 1'b1) begin errors++; $display("FAIL set_wins: got %b want 1", err_out); end
    checks++;
    err_clr_in = 1; out_ready = 1; @(negedge clk); err_clr_in = 0; out_ready = 0;
    in_valid = 1; type_in = T_ADDI; rd_in = 0; rs1_in = 0; imm_in = 32'h800;
    @(negedge clk); in_valid = 0;
`ifdef IMM_CHECK_EN
    if (err_out !== 1'b1 || out_inst !== 32'h8000_0013) begin
      errors++; $display("FAIL imm_range: err=%b inst=%h want 1/80000013", err_out, out_inst);
    end
`else
    if (err_out !== 1'b0 || out_inst !== 32'h8000_0013) begin
      errors++; $display("FAIL imm_range: err=%b inst=%h want 0/80000013", err_out, out_inst);
    end
`endif
    checks++;
    err_clr_in = 1; out_ready = 1; @(negedge clk); err_clr_in = 0; out_ready = 0;
    addr_m = addr_m + 12;
  endtask

  task automatic test_reset_mid();
    rec_t r;
    for (int i = 0; i < 3; i++) begin
      r = gen(); drive(r); in_valid = 1; @(negedge clk);
    end
    in_valid = 0;
    if (count_out !== 3'd3) begin errors++; $display("FAIL pre_reset_count: got %0d want 3", count_out); end
    checks++;
    #2 rst_in = 0;
    #1;
    if (out_valid !== 1'b0 || count_out !== '0 || in_ready !== 1'b0 || out_inst !== 32'h0) begin
      errors++; $display("FAIL mid_reset: valid=%b count=%0d ready=%b inst=%h want 0/0/0/0", out_valid, count_out, in_ready, out_inst);
    end
    checks++;
    @(negedge clk); rst_in = 1;
    in_valid = 1; type_in = T_LUI; rd_in = 1; imm_in = 32'hABCD_E000;
    @(negedge clk); in_valid = 0;
    if (out_addr !== BASE || out_inst !== 32'hABCD_E0B7) begin
      errors++; $display("FAIL after_reset: addr=%h inst=%h want %h/abcde0b7", out_addr, out_inst, BASE);
    end
    checks++;
    out_ready = 1; @(negedge clk); out_ready = 0;
    addr_m = BASE + 4;
    q.delete();
  endtask

  task automatic test_random();
    rec_t r; int t, f; logic [31:0] im; logic iv, ordy, clr, rdy, pu, po;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (out_valid !== (q.size() != 0) || count_out !== (DL + 1)'(q.size())) begin
        errors++; $display("FAIL rnd_occ[%0d]: valid=%b count=%0d want size %0d", cyc, out_valid, count_out, q.size());
      end
      checks++;
      if (in_ready !== (rdy_in && q.size() < 4)) begin
        errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, in_ready, rdy_in && q.size() < 4);
      end
      checks++;
      if (err_out !== 1'b0) begin errors++; $display("FAIL rnd_err[%0d]: got %b want 0", cyc, err_out); end
      checks++;
      if (q.size() != 0 && out_valid === 1'b1) begin
        decode(out_inst, t, f, im);
        if (t !== q[0].t || out_addr !== q[0].addr) begin
          errors++; $display("FAIL rt_head[%0d]: word=%h type=%0d addr=%h want type %0d addr %h", cyc, out_inst, t, out_addr, q[0].t, q[0].addr);
        end else begin
          if ((f != FS && f != FB && out_inst[11:7] !== q[0].rd) ||
              (f != FU && f != FJ && out_inst[19:15] !== q[0].rs1) ||
              ((f == FS || f == FB || f == FR) && out_inst[24:20] !== q[0].rs2) ||
              (f != FR && im !== q[0].imm)) begin
            errors++; $display("FAIL rt_fields[%0d]: word=%h imm=%h want rd=%0d rs1=%0d rs2=%0d imm=%h", cyc, out_inst, im, q[0].rd, q[0].rs1, q[0].rs2, q[0].imm);
          end
        end
        checks++;
      end
      rdy = ($urandom_range(0, 7) != 0); iv = 1'($urandom); ordy = 1'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      r = gen();
      pu = iv && rdy && q.size() < 4;
      po = ordy && rdy && q.size() != 0;
      if (po) void'(q.pop_front());
      if (pu) begin
        r.addr = clr ? BASE : addr_m; addr_m = r.addr + 4; q.push_back(r);
      end else if (rdy && clr) addr_m = BASE;
      rdy_in = rdy; in_valid = iv; out_ready = ordy; addr_clr_in = clr; drive(r);
    end
    @(negedge clk);
    rdy_in = 1; in_valid = 0; out_ready = 1; addr_clr_in = 0;
    repeat (6) @(negedge clk);
    out_ready = 0;
    if (out_valid !== 1'b0 || count_out !== '0) begin
      errors++; $display("FAIL rnd_drain: valid=%b count=%0d want 0/0", out_valid, count_out);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_full();
    test_error();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the instruction decoder: accepts decoded RV32I fields (type, rs1, rs2, rd, imm) and produces 32-bit machine words.
- Encoded words are buffered in a small FIFO, each tagged with a sequential byte address.
- Used to fill instruction memory from a stimulus/loader source and for decode round-trip checking: decoding the output must reproduce the input fields.

Parameters:
- DEPTH_LOG, 2, FIFO depth = 2**DEPTH_LOG entries.
- BASE_ADDR, 32'h0, address given to the first word after reset or addr_clr_in.

Ports:
- clk_in  in  1  clock, all state on rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global pause when low.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept.
- type_in  in  `TYPE_BIT  instruction type code from shared constants.
- rs1_in  in  5  source register 1.
- rs2_in  in  5  source register 2.
- rd_in  in  5  destination register.
- imm_in  in  32  immediate, decoder format: sign-extended; shamt zero-extended.
- addr_clr_in  in  1  restart addressing at BASE_ADDR.
- err_clr_in  in  1  clear sticky error.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- out_inst  out  32  encoded word at head.
- out_addr  out  32  address of head word.
- err_out  out  1  sticky encode error.
- count_out  out  DEPTH_LOG+1  FIFO occupancy.

Behaviour:
- Reset (rst_in low, async): FIFO empty, count_out=0, out_valid=0, out_inst=0, out_addr=0, err_out=0, push address=BASE_ADDR. in_ready=0 while reset is asserted; in-flight entries are discarded.
- Handshakes:
  - in_ready = rdy_in & !full.
  - Push when in_valid & in_ready.
  - Pop when out_valid & out_ready & rdy_in.
  - rdy_in low: no push, no pop, no state change; outputs hold.
- Latency: encoding is combinational on the inputs and written on push. A word pushed at edge N is visible at the head (out_valid=1) after edge N if the FIFO was empty. No fall-through in the same cycle.
- Full FIFO: in_ready=0 even if a pop occurs that cycle, so there is no push-on-pop when full. Push and pop in the same cycle when not full or empty: both happen, count unchanged.
- Empty FIFO: out_valid=0. out_inst and out_addr hold their last values.
- Addressing: each pushed entry stores the current push address, which then increments by 4 and wraps modulo 2^32.
  - addr_clr_in in a cycle without a push: next push gets BASE_ADDR.
  - addr_clr_in together with a push: that entry gets BASE_ADDR and the next gets BASE_ADDR+4.
  - Entries already in the FIFO keep their addresses.
- Encoding (standard RV32I formats; fields the format does not use are ignored):
  - U (LUI 0110111, AUIPC 0010111): {imm[31:12], rd, op}.
  - J (JAL 1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - I (JALR, loads, ALU-imm): {imm[11:0], rs1, f3, rd, op}.
  - Shifts SLLI/SRLI/SRAI: {f7, imm[4:0], rs1, f3, rd, op}; f7 = 0100000 for SRAI, otherwise 0000000.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - R: {f7, rs2, rs1, f3, rd, op}; f7 = 0100000 for SUB and SRA, otherwise 0000000.
  - funct3 values match the decoder's tables exactly.
  - Unknown type code: push 32'h00000013 (NOP) and set err_out.
- err_out is sticky. A set on the same edge as err_clr_in wins.

Optional Feature:
- IMM_CHECK_EN defined: on push, immediate range is checked. Any violation still pushes the truncated word and sets err_out. Checks:
  - I/S: imm must equal sign-extension of imm[11:0].
  - B: 13-bit signed, and imm[0]=0.
  - J: 21-bit signed, and imm[0]=0.
  - U: imm[11:0]=0.
  - Shifts: imm[31:5]=0.
- IMM_CHECK_EN undefined: out-of-range bits are silently dropped; err_out is set only for unknown types.

Decomposition:
- const.v (shared) holds `TYPE_BIT and the type codes, and gains opcode and funct3/funct7 constants so the encoder and decoder share one table.
- One sub-module, inst_fifo: a parametric FIFO (DEPTH_LOG, WIDTH=64 for {addr, inst}) with push/pop/full/empty/count.
- The encoder proper is a combinational function block inside inst_encoder.

Test Plan:
- LUI rd=5 imm=32'h12345000 -> out_inst 32'h123452B7, out_addr BASE_ADDR, out_valid one cycle after push.
- ADDI rd=1 rs1=0 imm=-1, then SUB rd=3 rs1=1 rs2=2 -> 32'hFFF00093 @0, then 32'h402081B3 @4.
- BEQ rs1=0 rs2=0 imm=-4 -> 32'hFE000EE3. SRAI rd=7 rs1=7 imm=3 -> 32'h4033D393.
- out_ready=0, push 5 words with DEPTH_LOG=2 -> in_ready falls after the 4th, count_out=4. Release out_ready -> words in order at addresses 0,4,8,12, then the 5th at 16. Toggling rdy_in low freezes count_out.
- Unknown type 7'h7F -> out_inst 32'h00000013, err_out=1. err_clr_in -> 0. With IMM_CHECK_EN, ADDI imm=32'h800 -> err_out=1.
- Drop rst_in mid-stream with 3 entries queued -> out_valid=0, count_out=0 immediately. After release, the next push gets BASE_ADDR. Random round-trip through the decoder reproduces all fields.
